// File: rtl/ifu_mem_responder.sv
// ifu_mem_responder: queues IFU line-miss tags, reads each line word-by-word from a
// 1-cycle SRAM and returns the assembled line with a single-cycle valid pulse.
module ifu_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 28,
    parameter int LINE_WIDTH = 128,
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            Clock,
    input  logic                            Rst,
    input  logic [TAG_WIDTH-1:0]            mem_reqTagIn,
    input  logic                            mem_reqTagValidIn,
    output logic                            mem_reqReadyOut,
    output logic [TAG_WIDTH-1:0]            mem_rspTagOut,
    output logic [LINE_WIDTH-1:0]           mem_rspInsLineOut,
    output logic                            mem_rspInsLineValidOut,
    output logic                            imem_rdEnOut,
    output logic [ADDR_WIDTH-1:0]           imem_rdAddrOut,
    input  logic [WORD_WIDTH-1:0]           imem_rdDataIn,
    output logic                            overflowOut,
    output logic [1:0]                      debug_stateOut,
    output logic [$clog2(FIFO_DEPTH):0]     debug_fifoCountOut
);
    localparam int WORDS = LINE_WIDTH / WORD_WIDTH;
    localparam int KW    = $clog2(WORDS);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int PAD   = ADDR_WIDTH - TAG_WIDTH - KW;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_RESP} state_t;

    state_t                 r_state, w_next;
    logic [TAG_WIDTH-1:0]   r_fifo [FIFO_DEPTH];
    logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [TAG_WIDTH-1:0]   r_cur_tag;
    logic [KW-1:0]          r_k, r_k_d;
    logic                   r_rd_d;
    logic                   r_overflow;
    logic [LINE_WIDTH-1:0]  r_line, w_line_next;
    logic [TAG_WIDTH-1:0]   r_rsp_tag;
    logic [LINE_WIDTH-1:0]  r_rsp_line;
    logic                   w_pop, w_push, w_rd_en, w_dup, w_ready;

    assign w_ready = r_count != CW'(FIFO_DEPTH);
    assign w_push  = mem_reqTagValidIn && w_ready && !w_dup;

    // A tag is a duplicate if it sits anywhere in the occupied window or is the line being fetched.
    always_comb begin
        w_dup = (r_state != S_IDLE) && (mem_reqTagIn == r_cur_tag);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ({1'b0, PW'(i) - r_rd_ptr} < r_count && r_fifo[i] == mem_reqTagIn) w_dup = 1'b1;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_pop   = 1'b0;
        w_rd_en = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_pop  = r_count != '0;
                w_next = w_pop ? S_READ : S_IDLE;
            end
            S_READ: begin
                w_rd_en = 1'b1;
                w_next  = (r_k == KW'(WORDS - 1)) ? S_DRAIN : S_READ;
            end
            S_DRAIN: w_next = S_RESP;
            S_RESP: begin
                w_pop  = r_count != '0;
                w_next = w_pop ? S_READ : S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_line_next = r_line;
        if (r_rd_d) w_line_next[int'(r_k_d)*WORD_WIDTH +: WORD_WIDTH] = imem_rdDataIn;
    end

    always_ff @(posedge Clock) begin
        if (w_push) r_fifo[r_wr_ptr] <= mem_reqTagIn;
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_cur_tag  <= '0;
            r_k        <= '0;
            r_k_d      <= '0;
            r_rd_d     <= 1'b0;
            r_overflow <= 1'b0;
            r_line     <= '0;
            r_rsp_tag  <= '0;
            r_rsp_line <= '0;
        end else begin
            r_state  <= w_next;
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            r_rd_d   <= w_rd_en;
            r_k_d    <= r_k;
            r_line   <= w_line_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_cur_tag <= r_fifo[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_k       <= '0;
            end else if (w_rd_en) begin
                r_k <= r_k + 1'b1;
            end
            if (mem_reqTagValidIn && !w_ready && !w_dup) r_overflow <= 1'b1;
            if (r_state == S_DRAIN) begin
                r_rsp_tag  <= r_cur_tag;
                r_rsp_line <= w_line_next;
            end
        end
    end

    assign mem_reqReadyOut        = w_ready;
    assign mem_rspTagOut          = r_rsp_tag;
    assign mem_rspInsLineOut      = r_rsp_line;
    assign mem_rspInsLineValidOut = r_state == S_RESP;
    assign imem_rdEnOut           = w_rd_en;
    assign imem_rdAddrOut         = w_rd_en ? {r_cur_tag, r_k, {PAD{1'b0}}} : '0;
    assign overflowOut            = r_overflow;
    assign debug_stateOut         = r_state;
    assign debug_fifoCountOut     = r_count;
endmodule

// File: tb/tb_ifu_mem_responder.sv
// tb_ifu_mem_responder: scoreboard bench; SRAM model returns its own address as data.
module tb_ifu_mem_responder;
    localparam int TW = 28;

    typedef struct {
        logic [TW-1:0] tag;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] req_tag;
    logic          req_valid;
    logic          ready;
    logic [TW-1:0] rsp_tag;
    logic [127:0]  rsp_line;
    logic          rsp_valid;
    logic          rd_en;
    logic [31:0]   rd_addr;
    logic [31:0]   rd_data = '0;
    logic          overflow;
    logic [1:0]    state;
    logic [2:0]    count;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    ifu_mem_responder dut (
        .Clock                  (clk),
        .Rst                    (rst),
        .mem_reqTagIn           (req_tag),
        .mem_reqTagValidIn      (req_valid),
        .mem_reqReadyOut        (ready),
        .mem_rspTagOut          (rsp_tag),
        .mem_rspInsLineOut      (rsp_line),
        .mem_rspInsLineValidOut (rsp_valid),
        .imem_rdEnOut           (rd_en),
        .imem_rdAddrOut         (rd_addr),
        .imem_rdDataIn          (rd_data),
        .overflowOut            (overflow),
        .debug_stateOut         (state),
        .debug_fifoCountOut     (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= rd_addr;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] exp_line(input logic [TW-1:0] t);
        return {t, 4'hC, t, 4'h8, t, 4'h4, t, 4'h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        chk("drain", sb.size(), 0);
        repeat (2) tick();
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_tag", rsp_tag, e.tag);
                chk("rsp_line", rsp_line, exp_line(e.tag));
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 1'b0;
        req_tag = '0;
        repeat (2) tick();
        chk("rst_valid", rsp_valid, 0);
        chk("rst_ready", ready, 1);
        chk("rst_rden", rd_en, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_state", state, 0);
        rst = 1'b0;
        tick();

        // single request, address sequence and latency
        req_tag = 28'h100;
        req_valid = 1'b1;
        n = cyc;
        sb.push_back('{28'h100, n + 7});
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rd_en", rd_en, 1);
            chk("rd_addr", rd_addr, 32'h1000 + 4 * k);
        end
        tick();
        chk("drain_rden", rd_en, 0);
        drain();

        // level-held request through the whole in-flight window
        req_tag = 28'h100;
        req_valid = 1'b1;
        n = cyc;
        sb.push_back('{28'h100, n + 7});
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("held_count", count <= 1, 1);
        end
        req_valid = 1'b0;
        drain();

        // fill to overflow
        n = cyc;
        for (int i = 1; i <= 6; i++) begin
            req_tag = TW'(i);
            req_valid = 1'b1;
            if (i <= 5) sb.push_back('{TW'(i), n + 7 + 6 * (i - 1)});
            else chk("ready_full", ready, 0);
            tick();
        end
        req_valid = 1'b0;
        chk("overflow_set", overflow, 1);
        drain();
        chk("overflow_sticky", overflow, 1);

        // reset during READ k=2
        req_tag = 28'h200;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        chk("mid_state", state, 1);
        chk("mid_addr", rd_addr, 32'h2008);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_state", state, 0);
        chk("abort_rden", rd_en, 0);
        chk("abort_count", count, 0);
        chk("abort_overflow", overflow, 0);
        repeat (20) tick();

        // back-to-back requests, RESP goes directly to READ
        req_tag = 28'hA;
        req_valid = 1'b1;
        n = cyc;
        sb.push_back('{28'hA, n + 7});
        tick();
        req_tag = 28'hB;
        sb.push_back('{28'hB, n + 13});
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !rsp_valid; i++) tick();
        chk("first_rsp_seen", rsp_valid, 1);
        tick();
        chk("resp_to_read", state, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
